// File: rtl/mips_scoreboard_rf.sv
// mips_scoreboard_rf
//   Register file with per-register busy (scoreboard) bits for an in-order
//   MIPS-style pipeline. Register 0 is hardwired to zero and never busy.
//
//   Parameters
//     DATA_W  register width
//     ADDR_W  register index width (depth = 2**ADDR_W)
//     NRD     number of read ports
//
//   Ports
//     clk1       clock, all state changes on the rising edge
//     rst_n      asynchronous active-low reset
//     rd_addr    NRD packed read indices, port i at [i*ADDR_W +: ADDR_W]
//     rd_data    NRD packed read values (writeback bypass applied)
//     rd_busy    per read port: source has a pending write (RAW hazard)
//     iss_valid  issue request claiming iss_dst
//     iss_dst    destination index being claimed
//     iss_grant  claim accepted (denied on WAW against a busy register)
//     wb_valid   writeback strobe
//     wb_addr    writeback index
//     wb_data    writeback value
//     pend_cnt   number of registers currently busy
//
//   Build option
//     MIPS_RF_INIT_INDEX_EN  when defined, reset loads register k with k.

module mips_scoreboard_rf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_dst,
    output logic                  iss_grant,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [ADDR_W:0]       pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wb_we;
    logic              claim_we;
    logic              cnt_inc;
    logic              cnt_dec;

    assign wb_we     = wb_valid && (wb_addr != '0);
    // A writeback in the same cycle releases the register, so a claim on it
    // is not a WAW conflict.
    assign iss_grant = iss_valid && ((iss_dst == '0) || !busy[iss_dst] ||
                                     (wb_valid && (wb_addr == iss_dst)));
    assign claim_we  = iss_grant && (iss_dst != '0);

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;
        assign ra  = rd_addr[g*ADDR_W +: ADDR_W];
        assign hit = wb_valid && (wb_addr == ra);
        assign rd_data[g*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                             hit        ? wb_data : mem[ra];
        assign rd_busy[g] = (ra != '0) && busy[ra] && !hit;
    end

    // Clear from writeback first, then set from claim: set wins on collision.
    always_comb begin
        busy_nxt = busy;
        if (wb_we)
            busy_nxt[wb_addr] = 1'b0;
        if (claim_we)
            busy_nxt[iss_dst] = 1'b1;
    end

    // Incremental count: +1 when a free register is claimed; -1 when a busy
    // register is written back and not re-claimed in the same cycle.
    assign cnt_inc = claim_we && !busy[iss_dst];
    assign cnt_dec = wb_we && busy[wb_addr] && !(claim_we && (iss_dst == wb_addr));

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            pend_cnt <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
`ifdef MIPS_RF_INIT_INDEX_EN
                mem[k] <= DATA_W'(k);
`else
                mem[k] <= '0;
`endif
            end
        end else begin
            if (wb_we)
                mem[wb_addr] <= wb_data;
            busy     <= busy_nxt;
            pend_cnt <= pend_cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
        end
    end

endmodule

// File: tb/tb_mips_scoreboard_rf.sv
module tb_mips_scoreboard_rf;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NREG = 32;

    logic             clk1 = 1'b0;
    logic             rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             iss_valid;
    logic [AW-1:0]    iss_dst;
    logic             iss_grant;
    logic             wb_valid;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;
    logic [AW:0]      pend_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: plain arrays, updated by the architectural rules.
    logic [DW-1:0] ref_data [NREG];
    bit            ref_busy [NREG];

    mips_scoreboard_rf #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .iss_grant (iss_grant),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pend();
        int n = 0;
        for (int k = 0; k < NREG; k++) n += ref_busy[k] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [DW-1:0] reset_val(input int k);
`ifdef MIPS_RF_INIT_INDEX_EN
        return DW'(k);
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) begin
            ref_data[k] = reset_val(k);
            ref_busy[k] = 1'b0;
        end
    endtask

    // One cycle: drive inputs, check combinational outputs against the
    // model, clock, update the model, check the registered count.
    task automatic apply(input bit iv, input int dst, input bit wv, input int wa,
                         input logic [DW-1:0] wd, input int ra0, input int ra1);
        int ra [NR];
        bit exp_grant;
        logic [DW-1:0] exp_d;
        bit exp_b;
        ra[0] = ra0;
        ra[1] = ra1;
        iss_valid = iv;
        iss_dst   = AW'(dst);
        wb_valid  = wv;
        wb_addr   = AW'(wa);
        wb_data   = wd;
        rd_addr   = {AW'(ra1), AW'(ra0)};
        #2;
        exp_grant = iv && (dst == 0 || !ref_busy[dst] || (wv && wa == dst));
        check("iss_grant", 64'(iss_grant), 64'(exp_grant));
        for (int p = 0; p < NR; p++) begin
            if (ra[p] == 0)              exp_d = '0;
            else if (wv && wa == ra[p])  exp_d = wd;
            else                         exp_d = ref_data[ra[p]];
            exp_b = (ra[p] != 0) && ref_busy[ra[p]] && !(wv && wa == ra[p]);
            check($sformatf("rd_data[%0d] r%0d", p, ra[p]), 64'(rd_data[p*DW +: DW]), 64'(exp_d));
            check($sformatf("rd_busy[%0d] r%0d", p, ra[p]), 64'(rd_busy[p]), 64'(exp_b));
        end
        @(posedge clk1);
        if (wv && wa != 0) begin
            ref_data[wa] = wd;
            ref_busy[wa] = 1'b0;
        end
        if (exp_grant && dst != 0) ref_busy[dst] = 1'b1;
        #1;
        check("pend_cnt", 64'(pend_cnt), 64'(model_pend()));
        iss_valid = 1'b0;
        wb_valid  = 1'b0;
    endtask

    function automatic int raddr();
        // Half the time confine to a small window to provoke hazards.
        return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7))
                                           : int'($urandom_range(0, NREG-1));
    endfunction

    initial begin
        rst_n = 1'b0; iss_valid = 1'b0; iss_dst = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; rd_addr = '0;
        model_reset();

        // Reset state.
        #3;
        rd_addr = {AW'(0), AW'(7)};
        #1;
        check("reset pend_cnt", 64'(pend_cnt), 64'd0);
        check("reset R7", 64'(rd_data[0 +: DW]), 64'(reset_val(7)));
        check("reset R0", 64'(rd_data[DW +: DW]), 64'd0);
        // Strobes during reset must not change state.
        iss_valid = 1'b1; iss_dst = AW'(3); wb_valid = 1'b1; wb_addr = AW'(3); wb_data = 32'hdead;
        @(posedge clk1); #1;
        check("reset ignores strobes", 64'(pend_cnt), 64'd0);
        iss_valid = 1'b0; wb_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk1); #1;

        // Claim R4, then a second (WAW) claim is denied.
        apply(1, 4, 0, 0, '0, 4, 0);
        apply(1, 4, 0, 0, '0, 4, 4);
        check("R4 busy count", 64'(pend_cnt), 64'd1);

        // Writeback R4=30 with port 0 reading R4 bypasses the value.
        apply(0, 0, 1, 4, 32'd30, 4, 9);
        check("R4 released", 64'(pend_cnt), 64'd0);

        // Claim + writeback of busy R5 in one cycle: granted, set wins.
        apply(1, 5, 0, 0, '0, 5, 0);
        apply(1, 5, 1, 5, 32'd55, 5, 4);
        apply(0, 0, 0, 0, '0, 5, 5);
        check("R5 value 55", 64'(rd_data[0 +: DW]), 64'd55);

        // R0 claim and writeback have no effect.
        apply(1, 0, 1, 0, 32'd99, 0, 0);
        apply(0, 0, 0, 0, '0, 0, 5);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            apply(bit'($urandom_range(0, 1)), raddr(), bit'($urandom_range(0, 1)), raddr(),
                  $urandom(), raddr(), raddr());
        end

        // Release every register, then claim R1..R31 back to back.
        for (int k = 1; k < NREG; k++) apply(0, 0, 1, k, DW'(k * 3), k, 0);
        check("all released", 64'(pend_cnt), 64'd0);
        for (int k = 1; k < NREG; k++) apply(1, k, 0, 0, '0, k, k - 1);
        check("pend_cnt full", 64'(pend_cnt), 64'd31);
        apply(1, 17, 0, 0, '0, 17, 31);
        check("pend_cnt saturated", 64'(pend_cnt), 64'd31);

        // Asynchronous reset mid-cycle.
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset pend_cnt", 64'(pend_cnt), 64'd0);
        for (int k = 0; k < NREG; k += 2) begin
            rd_addr = {AW'(k + 1), AW'(k)};
            #1;
            check($sformatf("reset busy r%0d", k), 64'(rd_busy), 64'd0);
            check($sformatf("reset data r%0d", k + 1), 64'(rd_data[DW +: DW]), 64'(reset_val(k + 1)));
        end
        #3 rst_n = 1'b1;
        @(posedge clk1); #1;
        apply(1, 9, 0, 0, '0, 9, 2);
        apply(0, 0, 0, 0, '0, 9, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
